mem_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register of the 8-bit TISC core.
- Takes the registered EX/MEM fields and performs loads and stores on the data memory over a req/ack handshake with variable latency.
- Drives `stall` back to the EX/MEM enable logic.
- Presents registered MEM/WB results to the register-file writeback.

---
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
// Latency: wires only; the master holds a request until the slave acknowledges it.
// Backpressure: the slave stretches an access by delaying dmem_ack, and the master waits.
// Ports (master view): dmem_req/dmem_we/dmem_addr/dmem_wdata out, dmem_ack/dmem_rdata in.
interface mem_access_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage of the TISC core: executes loads/stores from EX/MEM and registers MEM/WB results.
// Latency: 1 cycle for ALU pass-through; memory ops take launch + ack cycles (2 minimum).
// Backpressure: stall holds EX/MEM during launch and while waiting for ack; a timeout aborts.
// Ports: clk/rst_n; EX/MEM fields in; dmem bus (master modport); stall, wb_* writeback, sticky err.
module mem_access_unit #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int REG_AW  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [REG_AW-1:0] reg_write_addr,
    input  logic              reg_write_en,
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] data_write_addr,
    input  logic [DATA_W-1:0] data_write_data,
    input  logic [ADDR_W-1:0] data_read_addr,
    mem_access_unit_if.master dmem,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_reg_addr,
    output logic              wb_reg_en,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [REG_AW-1:0] cap_addr_q;
    logic              cap_en_q, cap_m2r_q;
    logic [DATA_W-1:0] cap_alu_q;
    logic              wb_valid_q, wb_en_q, err_q;
    logic [REG_AW-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;

    logic is_mem, illegal, last_cyc;
    logic pass_fire, launch, ack_fire, tmo_fire;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (launch) state_d = S_WAIT;
            S_WAIT:  if (ack_fire || tmo_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / event decode
    always_comb begin
        is_mem    = mem_write_en | mem_to_reg;
        illegal   = mem_write_en & mem_to_reg;
        last_cyc  = (cnt_q == 8'(TIMEOUT - 1));
        pass_fire = 1'b0;
        launch    = 1'b0;
        ack_fire  = 1'b0;
        tmo_fire  = 1'b0;
        if (state_q == S_IDLE) begin
            pass_fire = in_valid & ~is_mem;
            launch    = in_valid & is_mem;
        end else begin
            // req is always high in WAIT, so ack here is a real completion
            ack_fire  = dmem.dmem_ack;
            tmo_fire  = ~dmem.dmem_ack & last_cyc;
        end
        // The final WAIT cycle (ack or timeout) releases upstream on the same edge.
        // Gated by rst_n so a held upstream op cannot raise stall during reset.
        stall = rst_n & (launch | ((state_q == S_WAIT) & ~ack_fire & ~tmo_fire));
    end

    // Datapath: memory request, captured EX/MEM fields, MEM/WB register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_addr_q <= '0;
            cap_en_q   <= 1'b0;
            cap_m2r_q  <= 1'b0;
            cap_alu_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_en_q    <= 1'b0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            if (pass_fire) begin
                wb_valid_q <= 1'b1;
                wb_addr_q  <= reg_write_addr;
                wb_en_q    <= reg_write_en;
                wb_data_q  <= alu_out;
            end
            if (launch) begin
                // Store+load together runs as a store with no register write
                cap_addr_q <= reg_write_addr;
                cap_en_q   <= reg_write_en & ~illegal;
                cap_m2r_q  <= mem_to_reg & ~mem_write_en;
                cap_alu_q  <= alu_out;
                req_q      <= 1'b1;
                we_q       <= mem_write_en;
                addr_q     <= mem_write_en ? data_write_addr : data_read_addr;
                wdata_q    <= data_write_data;
                cnt_q      <= '0;
                if (illegal) err_q <= 1'b1;
            end
            if (state_q == S_WAIT) begin
                if (ack_fire) begin
                    req_q      <= 1'b0;
                    wb_valid_q <= 1'b1;
                    wb_addr_q  <= cap_addr_q;
                    wb_en_q    <= cap_en_q;
                    wb_data_q  <= cap_m2r_q ? dmem.dmem_rdata : cap_alu_q;
                end else if (tmo_fire) begin
                    req_q      <= 1'b0;
                    err_q      <= 1'b1;
                    wb_valid_q <= 1'b1;
                    wb_addr_q  <= cap_addr_q;
                    wb_en_q    <= 1'b0;
                    wb_data_q  <= cap_alu_q;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end
            end
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_reg_addr     = wb_addr_q;
    assign wb_reg_en       = wb_en_q;
    assign wb_data         = wb_data_q;
    assign err             = err_q;

endmodule
